// File: rtl/axi_multi_port_perf_monitor.sv
// Purpose : passive per-port AXI traffic monitor: saturating event counters,
//           outstanding write/read trackers with high watermarks, sticky error flags.
// Latency : readout returns one cycle after rd_req_i; err_o is registered.
// Backpressure: none. The block only observes handshakes and accepts a read every cycle.
// Optional: define AXI_PERF_MON_BUSY_CNT_EN to add the per-port busy-cycle counters
//           (idx 10 = write tracker non-zero, idx 11 = read tracker non-zero).
// Ports   : clk, rst_n (async, active-high); en_i gates event counters; clear_i zeroes all state;
//           aw/ar/w/b/r handshakes plus w/r last, one bit per port;
//           rd_req_i/rd_port_i/rd_idx_i -> rd_valid_o/rd_data_o; err_o = per-port OR of flags.
// Read map: 0 AW, 1 AR, 2 W beats, 3 W last, 4 B, 5 R beats, 6 R last,
//           7 write watermark, 8 read watermark, 9 {ovf, rd_unf, wr_unf}, 10/11 busy.
module axi_multi_port_perf_monitor #(
  parameter int NumPorts  = 2,
  parameter int CntWidth  = 32,
  parameter int OutWidth  = 8,
  parameter int DataWidth = 32,
  localparam int PortW    = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic [NumPorts-1:0]  aw_hs_i,
  input  logic [NumPorts-1:0]  ar_hs_i,
  input  logic [NumPorts-1:0]  w_hs_i,
  input  logic [NumPorts-1:0]  w_last_i,
  input  logic [NumPorts-1:0]  b_hs_i,
  input  logic [NumPorts-1:0]  r_hs_i,
  input  logic [NumPorts-1:0]  r_last_i,
  input  logic                 rd_req_i,
  input  logic [PortW-1:0]     rd_port_i,
  input  logic [3:0]           rd_idx_i,
  output logic                 rd_valid_o,
  output logic [DataWidth-1:0] rd_data_o,
  output logic [NumPorts-1:0]  err_o
);

`ifdef AXI_PERF_MON_BUSY_CNT_EN
  localparam int NumCnt = 9;
`else
  localparam int NumCnt = 7;
`endif
  localparam int MaxCO = (CntWidth > OutWidth) ? CntWidth : OutWidth;
  localparam int ValW  = (MaxCO > 3) ? MaxCO : 3;

  logic [CntWidth-1:0] cnt_q [NumPorts][NumCnt];
  logic [OutWidth-1:0] out_q [NumPorts][2];   // [0] write, [1] read
  logic [OutWidth-1:0] wm_q  [NumPorts][2];
  logic [2:0]          err_q [NumPorts];

  logic [NumCnt-1:0]   ev    [NumPorts];
  logic [1:0]          inc   [NumPorts];
  logic [1:0]          dec   [NumPorts];
  logic [OutWidth-1:0] trk_d [NumPorts][2];
  logic [2:0]          err_d [NumPorts];
  logic [ValW-1:0]     sel_val;

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      ev[p]    = '0;
      ev[p][0] = aw_hs_i[p];
      ev[p][1] = ar_hs_i[p];
      ev[p][2] = w_hs_i[p];
      ev[p][3] = w_hs_i[p] & w_last_i[p];
      ev[p][4] = b_hs_i[p];
      ev[p][5] = r_hs_i[p];
      ev[p][6] = r_hs_i[p] & r_last_i[p];
`ifdef AXI_PERF_MON_BUSY_CNT_EN
      // Busy cycles look at the tracker value held during this cycle.
      ev[p][7] = (out_q[p][0] != '0);
      ev[p][8] = (out_q[p][1] != '0);
`endif
      inc[p] = {ar_hs_i[p], aw_hs_i[p]};
      dec[p] = {r_hs_i[p] & r_last_i[p], b_hs_i[p]};
      err_d[p] = err_q[p];
      for (int t = 0; t < 2; t++) begin
        trk_d[p][t] = out_q[p][t];
        // Simultaneous increment and decrement cancel, so neither error can fire.
        if (inc[p][t] && !dec[p][t]) begin
          if (&out_q[p][t]) err_d[p][2] = 1'b1;
          else              trk_d[p][t] = out_q[p][t] + 1'b1;
        end else if (dec[p][t] && !inc[p][t]) begin
          if (out_q[p][t] == '0) err_d[p][t] = 1'b1;
          else                   trk_d[p][t] = out_q[p][t] - 1'b1;
        end
      end
    end
  end

  // Readout selects from current (pre-update) state, so a read coincident with
  // clear_i or with events returns the value before that cycle's changes.
  always_comb begin
    sel_val = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (rd_port_i == PortW'(p)) begin
        for (int c = 0; c < NumCnt; c++) begin
          if (rd_idx_i == 4'((c < 7) ? c : c + 3)) sel_val = ValW'(cnt_q[p][c]);
        end
        if (rd_idx_i == 4'd7) sel_val = ValW'(wm_q[p][0]);
        if (rd_idx_i == 4'd8) sel_val = ValW'(wm_q[p][1]);
        if (rd_idx_i == 4'd9) sel_val = ValW'(err_q[p]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int p = 0; p < NumPorts; p++) begin
        for (int c = 0; c < NumCnt; c++) cnt_q[p][c] <= '0;
        for (int t = 0; t < 2; t++) begin
          out_q[p][t] <= '0;
          wm_q[p][t]  <= '0;
        end
        err_q[p] <= '0;
      end
      err_o      <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_req_i;
      if (rd_req_i) rd_data_o <= DataWidth'(sel_val);
      if (clear_i) begin
        for (int p = 0; p < NumPorts; p++) begin
          for (int c = 0; c < NumCnt; c++) cnt_q[p][c] <= '0;
          for (int t = 0; t < 2; t++) begin
            out_q[p][t] <= '0;
            wm_q[p][t]  <= '0;
          end
          err_q[p] <= '0;
        end
        err_o <= '0;
      end else begin
        for (int p = 0; p < NumPorts; p++) begin
          for (int c = 0; c < NumCnt; c++) begin
            if (en_i && ev[p][c] && !(&cnt_q[p][c])) cnt_q[p][c] <= cnt_q[p][c] + 1'b1;
          end
          for (int t = 0; t < 2; t++) begin
            out_q[p][t] <= trk_d[p][t];
            if (trk_d[p][t] > wm_q[p][t]) wm_q[p][t] <= trk_d[p][t];
          end
          err_q[p] <= err_d[p];
          err_o[p] <= |err_d[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_multi_port_perf_monitor.sv
// Purpose : bench for axi_multi_port_perf_monitor; two instances (wide and narrow
//           counters/trackers) share stimulus and are checked against a reference model.
// Latency : reads are checked one cycle after the request.
// Backpressure: none; stimulus is applied every cycle.
module tb_axi_multi_port_perf_monitor;
  localparam int NP = 3;
  localparam int PW = 2;
`ifdef AXI_PERF_MON_BUSY_CNT_EN
  localparam longint BUSY_EXP = 10;
`else
  localparam longint BUSY_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          en_i, clear_i, rd_req;
  logic [NP-1:0] aw, ar, w, wl, b, r, rl;
  logic [PW-1:0] rd_port;
  logic [3:0]    rd_idx;
  logic          rv0, rv1;
  logic [31:0]   rd0, rd1;
  logic [NP-1:0] err0, err1;

  axi_multi_port_perf_monitor #(.NumPorts(NP), .CntWidth(32), .OutWidth(8), .DataWidth(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .clear_i(clear_i),
    .aw_hs_i(aw), .ar_hs_i(ar), .w_hs_i(w), .w_last_i(wl), .b_hs_i(b), .r_hs_i(r), .r_last_i(rl),
    .rd_req_i(rd_req), .rd_port_i(rd_port), .rd_idx_i(rd_idx),
    .rd_valid_o(rv0), .rd_data_o(rd0), .err_o(err0));

  axi_multi_port_perf_monitor #(.NumPorts(NP), .CntWidth(4), .OutWidth(3), .DataWidth(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .clear_i(clear_i),
    .aw_hs_i(aw), .ar_hs_i(ar), .w_hs_i(w), .w_last_i(wl), .b_hs_i(b), .r_hs_i(r), .r_last_i(rl),
    .rd_req_i(rd_req), .rd_port_i(rd_port), .rd_idx_i(rd_idx),
    .rd_valid_o(rv1), .rd_data_o(rd1), .err_o(err1));

  int total = 0;
  int bad   = 0;
  longint last0 = 0, last1 = 0;

  // Reference model: unbounded event counts clamped on read, integer trackers.
  int     cw [2] = '{32, 4};
  int     ow [2] = '{8, 3};
  longint m_cnt [2][NP][12];
  int     m_out [2][NP][2];
  int     m_wm  [2][NP][2];
  bit [2:0] m_err [2][NP];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(longint v, int wd);
    longint mx = (64'd1 << wd) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic longint m_read(int m, int p, int idx);
    if (p >= NP) return 0;
    if (idx <= 6) return sat(m_cnt[m][p][idx], cw[m]);
    if (idx == 7) return m_wm[m][p][0];
    if (idx == 8) return m_wm[m][p][1];
    if (idx == 9) return longint'(m_err[m][p]);
`ifdef AXI_PERF_MON_BUSY_CNT_EN
    if (idx == 10 || idx == 11) return sat(m_cnt[m][p][idx], cw[m]);
`endif
    return 0;
  endfunction

  task automatic m_reset();
    for (int m = 0; m < 2; m++)
      for (int p = 0; p < NP; p++) begin
        for (int k = 0; k < 12; k++) m_cnt[m][p][k] = 0;
        for (int t = 0; t < 2; t++) begin m_out[m][p][t] = 0; m_wm[m][p][t] = 0; end
        m_err[m][p] = 3'b000;
      end
  endtask

  task automatic m_step();
    bit e [7];
    bit up, down;
    int mx;
    if (clear_i) begin m_reset(); return; end
    for (int m = 0; m < 2; m++)
      for (int p = 0; p < NP; p++) begin
        e = '{aw[p], ar[p], w[p], w[p] & wl[p], b[p], r[p], r[p] & rl[p]};
        if (en_i) begin
          for (int k = 0; k < 7; k++) if (e[k]) m_cnt[m][p][k]++;
          if (m_out[m][p][0] > 0) m_cnt[m][p][10]++;
          if (m_out[m][p][1] > 0) m_cnt[m][p][11]++;
        end
        mx = (1 << ow[m]) - 1;
        for (int t = 0; t < 2; t++) begin
          up   = (t == 0) ? aw[p] : ar[p];
          down = (t == 0) ? b[p]  : (r[p] & rl[p]);
          if (up && !down) begin
            if (m_out[m][p][t] == mx) m_err[m][p][2] = 1'b1; else m_out[m][p][t]++;
          end else if (down && !up) begin
            if (m_out[m][p][t] == 0) m_err[m][p][t] = 1'b1; else m_out[m][p][t]--;
          end
          if (m_out[m][p][t] > m_wm[m][p][t]) m_wm[m][p][t] = m_out[m][p][t];
        end
      end
  endtask

  task automatic tick();
    logic vld;
    longint e0, e1;
    logic [NP-1:0] x0, x1;
    vld = rd_req; e0 = 0; e1 = 0;
    if (vld) begin
      e0 = m_read(0, int'(rd_port), int'(rd_idx));
      e1 = m_read(1, int'(rd_port), int'(rd_idx));
    end
    m_step();
    for (int p = 0; p < NP; p++) begin x0[p] = |m_err[0][p]; x1[p] = |m_err[1][p]; end
    @(posedge clk); #1;
    check("rd_valid0", rv0, vld);
    check("rd_valid1", rv1, vld);
    if (vld) begin last0 = e0; last1 = e1; end
    check("rd_data0", rd0, last0);
    check("rd_data1", rd1, last1);
    check("err0", err0, x0);
    check("err1", err1, x1);
  endtask

  task automatic idle();
    aw = '0; ar = '0; w = '0; wl = '0; b = '0; r = '0; rl = '0;
    clear_i = 1'b0; rd_req = 1'b0;
  endtask

  task automatic rd_const(input int p, input int idx, input longint x0, input longint x1);
    idle();
    rd_req = 1'b1; rd_port = PW'(p); rd_idx = 4'(idx);
    tick();
    rd_req = 1'b0;
    check($sformatf("const0_p%0d_i%0d", p, idx), rd0, x0);
    check($sformatf("const1_p%0d_i%0d", p, idx), rd1, x1);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    m_reset();
    @(posedge clk); #1;
    check("rst_valid0", rv0, 0);
    check("rst_data0", rd0, 0);
    check("rst_err0", err0, 0);
    check("rst_valid1", rv1, 0);
    rst_n = 1'b0;
    last0 = 0; last1 = 0;
  endtask

  initial begin
    idle(); en_i = 1'b1; rd_port = '0; rd_idx = '0;
    m_reset();
    @(posedge clk); #1;
    do_reset();
    rd_const(0, 0, 0, 0);
    rd_const(1, 8, 0, 0);

    // Port 0: 5 AW, five 4-beat W bursts, 5 B.
    for (int i = 0; i < 5; i++) begin idle(); aw[0] = 1'b1; tick(); end
    for (int i = 0; i < 20; i++) begin idle(); w[0] = 1'b1; wl[0] = (i % 4 == 3); tick(); end
    for (int i = 0; i < 5; i++) begin idle(); b[0] = 1'b1; tick(); end
    rd_const(0, 0, 5, 5);
    rd_const(0, 2, 20, 15);
    rd_const(0, 3, 5, 5);
    rd_const(0, 4, 5, 5);
    rd_const(0, 7, 5, 5);
    rd_const(0, 9, 0, 0);

    // Port 1: tracker at 2, AR and R last together leave it at 2.
    for (int i = 0; i < 2; i++) begin idle(); ar[1] = 1'b1; tick(); end
    idle(); ar[1] = 1'b1; r[1] = 1'b1; rl[1] = 1'b1; tick();
    rd_const(1, 1, 3, 3);
    rd_const(1, 6, 1, 1);
    rd_const(1, 8, 2, 2);
    idle(); ar[1] = 1'b1; tick();
    rd_const(1, 8, 3, 3);
    rd_const(0, 0, 5, 5);

    // Write underflow on port 0, sticky until clear.
    idle(); b[0] = 1'b1; tick();
    check("err_o_bit0", err0[0], 1);
    rd_const(0, 9, 1, 1);
    rd_const(0, 9, 1, 1);
    idle(); clear_i = 1'b1; tick();
    rd_const(0, 9, 0, 0);
    check("err_o_cleared", err0, 0);

    // 20 AR on port 2: narrow instance saturates at 15 and stays there.
    for (int i = 0; i < 20; i++) begin idle(); ar[2] = 1'b1; tick(); end
    rd_const(2, 1, 20, 15);
    rd_const(2, 1, 20, 15);

    // en_i=0 gates counters but not trackers/watermarks; clear beats a same-cycle AW.
    idle(); clear_i = 1'b1; tick();
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin idle(); aw[0] = 1'b1; tick(); end
    en_i = 1'b1;
    rd_const(0, 0, 0, 0);
    rd_const(0, 7, 3, 3);
    idle(); clear_i = 1'b1; aw[0] = 1'b1; rd_req = 1'b1; rd_port = 2'd0; rd_idx = 4'd7; tick();
    check("read_with_clear", rd0, 3);
    rd_const(0, 7, 0, 0);
    rd_const(0, 0, 0, 0);

    // Busy counter: AW then B ten cycles later.
    idle(); aw[0] = 1'b1; tick();
    for (int i = 0; i < 9; i++) begin idle(); tick(); end
    idle(); b[0] = 1'b1; tick();
    rd_const(0, 10, BUSY_EXP, BUSY_EXP);

    // Unmapped port / index read as zero.
    rd_const(3, 0, 0, 0);
    rd_const(0, 12, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      aw = '0; ar = '0; w = '0; wl = '0; b = '0; r = '0; rl = '0;
      for (int p = 0; p < NP; p++) begin
        aw[p] = ($urandom_range(0, 99) < 30);
        ar[p] = ($urandom_range(0, 99) < 30);
        w[p]  = ($urandom_range(0, 99) < 50);
        wl[p] = ($urandom_range(0, 99) < 30);
        b[p]  = ($urandom_range(0, 99) < 28);
        r[p]  = ($urandom_range(0, 99) < 50);
        rl[p] = ($urandom_range(0, 99) < 50);
      end
      en_i    = ($urandom_range(0, 99) < 90);
      clear_i = ($urandom_range(0, 99) < 1);
      rd_req  = ($urandom_range(0, 99) < 70);
      rd_port = PW'($urandom_range(0, 3));
      rd_idx  = 4'($urandom_range(0, 12));
      tick();
    end

    // Reset in the middle of a pending read.
    idle(); en_i = 1'b1; aw = '1; rd_req = 1'b1; rd_port = 2'd0; rd_idx = 4'd0;
    do_reset();
    rd_const(0, 0, 0, 0);
    rd_const(0, 7, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
